mux4_rr_arbiter: RTL and testbench

- Shares one W-bit output channel among four requesters.
- Drives the select of a 4:1 data mux with a round-robin grant and an optional burst allowance.
- Holds the selected word in a single-entry output register with a valid/ready handshake.
- Sits between four 2-bit producers and one downstream consumer in the npc datapath.

---
 rtl/mux4_rr_arbiter.sv | 102 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter with burst allowance feeding a single-entry
// valid/ready output register that carries the selected word and its source index.
module mux4_rr_arbiter #(
  parameter int W     = 2,
  parameter int BURST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic [W-1:0] din3,
  output logic [3:0]   ack,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  output logic         busy
);

  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] BMAX = CW'(BURST - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state, state_nx;
  logic [1:0]     last_grant;
  logic [CW-1:0]  burst_cnt;
  logic [1:0]     g;
  logic [1:0]     idx;
  logic [3:0]     others;
  logic           keep;
  logic           found;
  logic           can_load;
  logic           load;
  logic [W-1:0]   din_g;

  // burst_cnt never exceeds BMAX, so "!= BMAX" is the "< BURST-1" test
  always_comb begin
    others             = req;
    others[last_grant] = 1'b0;
    keep  = req[last_grant] && ((burst_cnt != BMAX) || (others == 4'b0000));
    g     = last_grant;
    idx   = last_grant;
    found = 1'b0;
    if (!keep) begin
      for (int unsigned k = 1; k <= 4; k++) begin
        idx = last_grant + 2'(k);
        if (!found && req[idx]) begin
          g     = idx;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (g)
      2'd0:    din_g = din0;
      2'd1:    din_g = din1;
      2'd2:    din_g = din2;
      default: din_g = din3;
    endcase
  end

  assign can_load  = (state == EMPTY) || out_ready;
  assign load      = can_load && (|req) && !rst;
  assign ack       = load ? (4'b0001 << g) : 4'b0000;
  assign out_valid = (state == FULL);
  assign busy      = out_valid;

  always_comb begin
    state_nx = state;
    if (load)
      state_nx = FULL;
    else if ((state == FULL) && out_ready)
      state_nx = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= 2'd3;
      burst_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        out_data   <= din_g;
        out_sel    <= g;
        last_grant <= g;
        if (g == last_grant)
          burst_cnt <= (burst_cnt != BMAX) ? burst_cnt + 1'b1 : BMAX;
        else
          burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: instance a (BURST=1) and instance b (BURST=3) share
// stimulus; each scenario checks the instance it targets via scoreboards.
module tb_mux4_rr_arbiter;

  localparam int W = 2;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] din0, din1, din2, din3;
  logic         out_ready;

  logic [3:0]   a_ack,   b_ack;
  logic         a_valid, b_valid;
  logic [W-1:0] a_data,  b_data;
  logic [1:0]   a_sel,   b_sel;
  logic         a_busy,  b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W+1:0] sb_a[$];
  logic [W+1:0] sb_b[$];
  logic [W+1:0] exp_e;

  mux4_rr_arbiter #(.W(W), .BURST(1)) dut_a (
    .clk(clk), .rst(rst), .req(req),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .ack(a_ack), .out_valid(a_valid), .out_ready(out_ready),
    .out_data(a_data), .out_sel(a_sel), .busy(a_busy)
  );

  mux4_rr_arbiter #(.W(W), .BURST(3)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .ack(b_ack), .out_valid(b_valid), .out_ready(out_ready),
    .out_data(b_data), .out_sel(b_sel), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input logic [W-1:0] d0, d1, d2, d3);
    din0 = d0; din1 = d1; din2 = d2; din3 = d3;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb_a.delete();
    sb_b.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    set_din(2'd1, 2'd2, 2'd3, 2'd1);
    tick();
    tick();
    #1;
    n_checks++;
    if ({a_valid, a_busy, a_sel, a_data} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_a: got valid=%b busy=%b sel=%0d data=%0d, want all 0", a_valid, a_busy, a_sel, a_data);
    end
    n_checks++;
    if ({b_valid, b_busy, b_sel, b_data} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_b: got valid=%b busy=%b sel=%0d data=%0d, want all 0", b_valid, b_busy, b_sel, b_data);
    end
    n_checks++;
    if (a_ack !== 4'b0000 || b_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ack: got a=%b b=%b, want 0000 while rst", a_ack, b_ack);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_din(2'b10, 2'b00, 2'b00, 2'b00);
    req = 4'b0001; out_ready = 1'b1;
    #1;
    n_checks++;
    if (a_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ack: got %b want 0001", a_ack);
    end
    sb_a.push_back({2'd0, 2'b10});
    tick();
    req = 4'b0000;
    #1;
    n_checks++;
    if (sb_a.size() == 0) begin
      n_fail++;
      $display("FAIL single_out: scoreboard empty");
    end else begin
      exp_e = sb_a.pop_front();
      if ({a_valid, a_sel, a_data} !== {1'b1, exp_e}) begin
        n_fail++;
        $display("FAIL single_out: got v=%b sel=%0d data=%b want v=1 sel=%0d data=%b", a_valid, a_sel, a_data, exp_e[3:2], exp_e[1:0]);
      end
    end
    tick();
    n_checks++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got valid=%b busy=%b want 0", a_valid, a_busy);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] gexp;
    do_reset();
    set_din(2'd0, 2'd1, 2'd2, 2'd3);
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i > 0) begin
        n_checks++;
        if (sb_a.size() == 0) begin
          n_fail++;
          $display("FAIL rr_out[%0d]: scoreboard empty", i);
        end else begin
          exp_e = sb_a.pop_front();
          if ({a_valid, a_sel, a_data} !== {1'b1, exp_e}) begin
            n_fail++;
            $display("FAIL rr_out[%0d]: got v=%b sel=%0d data=%0d want v=1 sel=%0d data=%0d", i, a_valid, a_sel, a_data, exp_e[3:2], exp_e[1:0]);
          end
        end
      end
      gexp = 2'(i % 4);
      n_checks++;
      if (a_ack !== (4'b0001 << gexp)) begin
        n_fail++;
        $display("FAIL rr_ack[%0d]: got %b want %b", i, a_ack, 4'b0001 << gexp);
      end
      sb_a.push_back({gexp, gexp});
      tick();
    end
    n_checks++;
    exp_e = sb_a.pop_front();
    if ({a_valid, a_sel, a_data} !== {1'b1, exp_e}) begin
      n_fail++;
      $display("FAIL rr_out_last: got v=%b sel=%0d data=%0d want v=1 sel=%0d", a_valid, a_sel, a_data, exp_e[3:2]);
    end
    req = 4'b0000;
  endtask

  task automatic test_burst();
    logic [3:0] treq[13];
    logic [1:0] tg[13];
    logic [1:0] gexp;
    for (int i = 0; i < 13; i++) begin
      if (i < 7)       begin treq[i] = 4'b0101; tg[i] = (i >= 3 && i <= 5) ? 2'd2 : 2'd0; end
      else if (i < 12) begin treq[i] = 4'b0001; tg[i] = 2'd0; end
      else             begin treq[i] = 4'b0101; tg[i] = 2'd2; end
    end
    do_reset();
    set_din(2'd0, 2'd1, 2'd2, 2'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      req = treq[i];
      #1;
      if (i > 0) begin
        n_checks++;
        if (sb_b.size() == 0) begin
          n_fail++;
          $display("FAIL burst_out[%0d]: scoreboard empty", i);
        end else begin
          exp_e = sb_b.pop_front();
          if ({b_valid, b_sel, b_data} !== {1'b1, exp_e}) begin
            n_fail++;
            $display("FAIL burst_out[%0d]: got v=%b sel=%0d data=%0d want v=1 sel=%0d data=%0d", i, b_valid, b_sel, b_data, exp_e[3:2], exp_e[1:0]);
          end
        end
      end
      gexp = tg[i];
      n_checks++;
      if (b_ack !== (4'b0001 << gexp)) begin
        n_fail++;
        $display("FAIL burst_ack[%0d]: got %b want %b", i, b_ack, 4'b0001 << gexp);
      end
      sb_b.push_back({gexp, gexp});
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_din(2'b00, 2'b01, 2'b10, 2'b11);
    req = 4'b0010; out_ready = 1'b1;
    #1;
    n_checks++;
    if (a_ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_first_ack: got %b want 0010", a_ack);
    end
    sb_a.push_back({2'd1, 2'b01});
    tick();
    req = 4'b1111; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (a_ack !== 4'b0000 || {a_valid, a_sel, a_data} !== {1'b1, sb_a[0]}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ack=%b v=%b sel=%0d data=%b want ack=0000 v=1 sel=1 data=01", i, a_ack, a_valid, a_sel, a_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (a_ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_release_ack: got %b want 0100", a_ack);
    end
    exp_e = sb_a.pop_front();
    sb_a.push_back({2'd2, 2'b10});
    tick();
    req = 4'b0000;
    n_checks++;
    exp_e = sb_a.pop_front();
    if ({a_valid, a_sel, a_data} !== {1'b1, exp_e}) begin
      n_fail++;
      $display("FAIL bp_release_out: got v=%b sel=%0d data=%b want v=1 sel=2 data=10", a_valid, a_sel, a_data);
    end
  endtask

  // Continues from the FULL sel=2 state left by test_backpressure.
  task automatic test_withdrawal();
    req = 4'b0010; out_ready = 1'b0;
    #1;
    n_checks++;
    if (a_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL wd_ack_held: got %b want 0000", a_ack);
    end
    tick();
    req = 4'b0000;
    #1;
    n_checks++;
    if (a_ack !== 4'b0000 || a_valid !== 1'b1 || a_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL wd_after: got ack=%b v=%b sel=%0d want ack=0000 v=1 sel=2", a_ack, a_valid, a_sel);
    end
    tick();
    req = 4'b1111; out_ready = 1'b1;
    #1;
    n_checks++;
    if (a_ack !== 4'b1000) begin
      n_fail++;
      $display("FAIL wd_pointer: got %b want 1000", a_ack);
    end
    sb_a.push_back({2'd3, 2'b11});
    tick();
    req = 4'b0000;
    #1;
    n_checks++;
    exp_e = sb_a.pop_front();
    if ({a_valid, a_sel, a_data} !== {1'b1, exp_e} || a_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL wd_out: got v=%b sel=%0d data=%b ack=%b want v=1 sel=3 data=11 ack=0000", a_valid, a_sel, a_data, a_ack);
    end
    tick();
    n_checks++;
    if (a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_drain: got valid=%b want 0", a_valid);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_din(2'b01, 2'b10, 2'b10, 2'b11);
    req = 4'b1000; out_ready = 1'b1;
    tick();
    req = 4'b1111; out_ready = 1'b0; rst = 1'b1;
    #1;
    n_checks++;
    if (a_ack !== 4'b0000 || b_ack !== 4'b0000 || a_valid !== 1'b1 || a_data !== 2'b11) begin
      n_fail++;
      $display("FAIL mr_during: got ack_a=%b ack_b=%b v=%b data=%b want 0000 0000 1 11", a_ack, b_ack, a_valid, a_data);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (a_valid !== 1'b0 || a_data !== 2'b00 || a_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL mr_after: got v=%b data=%b ack=%b want 0 00 0001", a_valid, a_data, a_ack);
    end
    sb_a.push_back({2'd0, 2'b01});
    tick();
    req = 4'b0000;
    n_checks++;
    exp_e = sb_a.pop_front();
    if ({a_valid, a_sel, a_data} !== {1'b1, exp_e}) begin
      n_fail++;
      $display("FAIL mr_first: got v=%b sel=%0d data=%b want v=1 sel=0 data=01", a_valid, a_sel, a_data);
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
    set_din(2'd0, 2'd0, 2'd0, 2'd0);
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_withdrawal();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
